// File: rtl/instruc_loader_if.sv
// Byte-in / instruction-out bundle between the UART receiver, instruc_loader and memory_instruc.
interface instruc_loader_if #(
   parameter int SIZE_ADDR_PC = 32,
   parameter int SIZE_BYTE    = 8
);
   logic                    i_load_start;
   logic [SIZE_BYTE-1:0]    i_rx_data;
   logic                    i_rx_done;
   logic [SIZE_ADDR_PC-1:0] o_instruction_address;
   logic [SIZE_ADDR_PC-1:0] o_instruction;
   logic                    o_flag_write_intruc;
   logic                    o_busy;
   logic                    o_load_done;

   modport master (
      output i_load_start, i_rx_data, i_rx_done,
      input  o_instruction_address, o_instruction, o_flag_write_intruc, o_busy, o_load_done
   );

   modport slave (
      input  i_load_start, i_rx_data, i_rx_done,
      output o_instruction_address, o_instruction, o_flag_write_intruc, o_busy, o_load_done
   );
endinterface

// File: rtl/instruc_loader.sv
// Packs UART bytes big-endian into instruction words and writes them to memory_instruc
// until the HALT word or the last memory word has been written.
//
// state | meaning
// IDLE  | waiting for i_load_start, bytes ignored
// RECV  | collecting bytes of the current word
// WRITE | one-cycle write strobe for the assembled word
// DONE  | session finished, o_load_done held until next start
module instruc_loader #(
   parameter int                      SIZE_ADDR_PC    = 32,
   parameter int                      SIZE_BYTE       = 8,
   parameter int                      MEM_DEPTH_WORDS = 64,
   parameter logic [SIZE_ADDR_PC-1:0] HALT_INSTR      = 32'hFFFF_FFFF
) (
   input logic                i_clk,
   input logic                i_reset,
   instruc_loader_if.slave    bus
);
   localparam int BYTES_PER_WORD = SIZE_ADDR_PC / SIZE_BYTE;
   localparam int CNT_W          = $clog2(BYTES_PER_WORD);
   localparam int SH_W           = SIZE_ADDR_PC - SIZE_BYTE;
   localparam logic [CNT_W-1:0]        LAST_CNT  = CNT_W'(BYTES_PER_WORD - 1);
   localparam logic [SIZE_ADDR_PC-1:0] ADDR_STEP = SIZE_ADDR_PC'(4);
   localparam logic [SIZE_ADDR_PC-1:0] LAST_ADDR = SIZE_ADDR_PC'(4 * (MEM_DEPTH_WORDS - 1));

   typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_WRITE, ST_DONE} state_t;

   state_t                  state_q, state_d;
   logic [SIZE_ADDR_PC-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SH_W-1:0]         sh_q, sh_d;
   logic [SIZE_ADDR_PC-1:0] out_addr_q, out_addr_d;
   logic [SIZE_ADDR_PC-1:0] instr_q, instr_d;
   logic                    wr_q, wr_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [SH_W-1:0]         sh_shifted;

   // Only the first three bytes are held here; the fourth goes straight into instr.
   assign sh_shifted = {sh_q[SH_W-SIZE_BYTE-1:0], bus.i_rx_data};

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         sh_q       <= '0;
         out_addr_q <= '0;
         instr_q    <= '0;
         wr_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         out_addr_q <= out_addr_d;
         instr_q    <= instr_d;
         wr_q       <= wr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      out_addr_d = out_addr_q;
      instr_d    = instr_q;
      wr_d       = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.i_load_start) begin
               state_d = ST_RECV;
               addr_d  = '0;
               cnt_d   = '0;
            end
         end
         ST_RECV: begin
            if (bus.i_rx_done) begin
               if (cnt_q == LAST_CNT) begin
                  state_d    = ST_WRITE;
                  instr_d    = {sh_q, bus.i_rx_data};
                  out_addr_d = addr_q;
                  wr_d       = 1'b1;
                  cnt_d      = '0;
               end else begin
                  sh_d  = sh_shifted;
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_WRITE: begin
            // Last memory word doubles as the wrap guard for the address counter.
            if (instr_q == HALT_INSTR || addr_q == LAST_ADDR) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RECV;
               addr_d  = addr_q + ADDR_STEP;
               if (bus.i_rx_done) begin
                  sh_d  = sh_shifted;
                  cnt_d = CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RECV) || (state_d == ST_WRITE);
      done_d = (state_d == ST_DONE);
   end

   assign bus.o_instruction_address = out_addr_q;
   assign bus.o_instruction         = instr_q;
   assign bus.o_flag_write_intruc   = wr_q;
   assign bus.o_busy                = busy_q;
   assign bus.o_load_done           = done_q;
endmodule

// File: tb/tb_instruc_loader.sv
// Self-checking bench for instruc_loader: random byte streams compared against a word-level model.
module tb_instruc_loader;
   logic i_clk = 1'b0;
   logic i_reset;
   always #5 i_clk = ~i_clk;

   instruc_loader_if bus ();
   instruc_loader dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // observed writes
   logic [31:0] got_addr[$];
   logic [31:0] got_instr[$];
   int          got_t[$];
   bit          got_busy[$];
   always @(negedge i_clk) begin
      if (bus.o_flag_write_intruc === 1'b1) begin
         got_addr.push_back(bus.o_instruction_address);
         got_instr.push_back(bus.o_instruction);
         got_t.push_back(cyc);
         got_busy.push_back(bus.o_busy === 1'b1);
      end
   end

   // bytes of the current session, with the cycle each one was taken
   logic [7:0]  s_bytes[$];
   int          s_t[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_instr[$];
   int          exp_t[$];

   // Word-level model: pack in fours, stop after HALT or the 64th word.
   function void model_build();
      int k;
      logic [31:0] w;
      exp_addr.delete(); exp_instr.delete(); exp_t.delete();
      k = 0;
      for (int i = 0; i + 3 < s_bytes.size(); i += 4) begin
         w = {s_bytes[i], s_bytes[i+1], s_bytes[i+2], s_bytes[i+3]};
         exp_addr.push_back(32'(4 * k));
         exp_instr.push_back(w);
         exp_t.push_back(s_t[i+3]);
         k++;
         if (w == 32'hFFFF_FFFF || k == 64) break;
      end
   endfunction

   task send_byte(input logic [7:0] b, input int gap);
      bus.i_rx_data = b;
      bus.i_rx_done = 1'b1;
      @(negedge i_clk);
      bus.i_rx_done = 1'b0;
      s_bytes.push_back(b);
      s_t.push_back(cyc);
      repeat (gap) @(negedge i_clk);
   endtask

   task send_word(input logic [31:0] w, input int gap);
      for (int j = 0; j < 4; j++) begin
         logic [7:0] b;
         b = w[31-8*j -: 8];
         send_byte(b, gap);
      end
   endtask

   task pulse_start();
      bus.i_load_start = 1'b1;
      @(negedge i_clk);
      bus.i_load_start = 1'b0;
   endtask

   task start_session();
      s_bytes.delete(); s_t.delete();
      got_addr.delete(); got_instr.delete(); got_t.delete(); got_busy.delete();
      pulse_start();
   endtask

   task test_reset();
      bus.i_load_start = 1'b0;
      bus.i_rx_done    = 1'b0;
      bus.i_rx_data    = '0;
      i_reset = 1'b1;
      #2 i_reset = 1'b0;
      repeat (2) @(negedge i_clk);
      i_reset = 1'b1;
      @(negedge i_clk);
      checks++; if (bus.o_instruction_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected %h", bus.o_instruction_address, 32'h0); end
      checks++; if (bus.o_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", bus.o_instruction, 32'h0); end
      checks++; if (bus.o_flag_write_intruc !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", bus.o_flag_write_intruc); end
      checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
      checks++; if (bus.o_load_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.o_load_done); end
      got_addr.delete(); got_instr.delete(); got_t.delete(); got_busy.delete();
      send_word(32'hA1B2C3D4, 0);
      repeat (3) @(negedge i_clk);
      checks++; if (got_addr.size() != 0) begin errors++; $display("FAIL idle_no_strobe: got %0d strobes expected 0", got_addr.size()); end
      checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.o_busy); end
   endtask

   task test_basic();
      start_session();
      checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %b expected 1", bus.o_busy); end
      send_word(32'h12345678, 1);
      repeat (2) @(negedge i_clk);
      checks++; if (got_addr.size() != 1) begin errors++; $display("FAIL basic_count1: got %0d expected 1", got_addr.size()); end
      else begin
         checks++; if (got_addr[0] !== 32'h0) begin errors++; $display("FAIL basic_addr0: got %h expected %h", got_addr[0], 32'h0); end
         checks++; if (got_instr[0] !== 32'h12345678) begin errors++; $display("FAIL basic_instr0: got %h expected %h", got_instr[0], 32'h12345678); end
         checks++; if (got_busy[0] !== 1'b1) begin errors++; $display("FAIL basic_busy_strobe: got %b expected 1", got_busy[0]); end
         checks++; if (got_t[0] != s_t[3]) begin errors++; $display("FAIL basic_latency: got cycle %0d expected %0d", got_t[0], s_t[3]); end
      end
      send_word(32'hFFFF_FFFF, 0);
      repeat (2) @(negedge i_clk);
      checks++; if (got_addr.size() != 2) begin errors++; $display("FAIL basic_count2: got %0d expected 2", got_addr.size()); end
      else begin
         checks++; if (got_addr[1] !== 32'h4) begin errors++; $display("FAIL basic_addr1: got %h expected %h", got_addr[1], 32'h4); end
         checks++; if (got_instr[1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL basic_halt: got %h expected %h", got_instr[1], 32'hFFFF_FFFF); end
      end
      checks++; if (bus.o_load_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", bus.o_load_done); end
      checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b expected 0", bus.o_busy); end
   endtask

   task test_full();
      start_session();
      for (int w = 0; w < 64; w++) begin
         logic [31:0] word;
         word = $urandom();
         word[31:24] = 8'($urandom_range(0, 254));
         send_word(word, $urandom_range(0, 1));
      end
      send_word(32'h0BAD_F00D, 0);
      repeat (3) @(negedge i_clk);
      model_build();
      checks++; if (got_addr.size() != exp_addr.size()) begin errors++; $display("FAIL full_count: got %0d expected %0d", got_addr.size(), exp_addr.size()); end
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
         checks++;
         if (got_addr[i] !== exp_addr[i] || got_instr[i] !== exp_instr[i] || got_t[i] != exp_t[i]) begin
            errors++;
            $display("FAIL full_write[%0d]: got %h@%h cyc %0d expected %h@%h cyc %0d", i, got_instr[i], got_addr[i], got_t[i], exp_instr[i], exp_addr[i], exp_t[i]);
         end
      end
      checks++; if (got_addr.size() == 64 && got_addr[63] !== 32'hFC) begin errors++; $display("FAIL full_last_addr: got %h expected %h", got_addr[63], 32'hFC); end
      checks++; if (bus.o_load_done !== 1'b1) begin errors++; $display("FAIL full_done: got %b expected 1", bus.o_load_done); end
   endtask

   task test_back_to_back();
      start_session();
      for (int w = 0; w < 12; w++) begin
         for (int j = 0; j < 4; j++) begin
            logic [7:0] b;
            b = (j == 0) ? 8'($urandom_range(0, 254)) : 8'($urandom());
            send_byte(b, (j == 3) ? 0 : $urandom_range(0, 2));
            if (w == 5 && j == 1) pulse_start();
         end
      end
      send_word(32'hFFFF_FFFF, 0);
      send_word(32'h5555_AAAA, 0);
      repeat (3) @(negedge i_clk);
      model_build();
      checks++; if (got_addr.size() != exp_addr.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_addr.size(), exp_addr.size()); end
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
         checks++;
         if (got_addr[i] !== exp_addr[i] || got_instr[i] !== exp_instr[i] || got_t[i] != exp_t[i] || got_busy[i] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write[%0d]: got %h@%h cyc %0d busy %b expected %h@%h cyc %0d busy 1", i, got_instr[i], got_addr[i], got_t[i], got_busy[i], exp_instr[i], exp_addr[i], exp_t[i]);
         end
      end
      checks++; if (bus.o_load_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", bus.o_load_done); end
   endtask

   task test_reset_mid();
      logic [31:0] w;
      start_session();
      send_byte(8'hDE, 1);
      send_byte(8'hAD, 1);
      i_reset = 1'b0;
      @(negedge i_clk);
      checks++; if (got_addr.size() != 0) begin errors++; $display("FAIL rstmid_no_strobe: got %0d expected 0", got_addr.size()); end
      checks++; if (bus.o_busy !== 1'b0 || bus.o_load_done !== 1'b0 || bus.o_instruction !== 32'h0 || bus.o_instruction_address !== 32'h0) begin
         errors++; $display("FAIL rstmid_outputs: got busy %b done %b instr %h addr %h expected all 0", bus.o_busy, bus.o_load_done, bus.o_instruction, bus.o_instruction_address);
      end
      i_reset = 1'b1;
      @(negedge i_clk);
      start_session();
      w = $urandom();
      w[31:24] = 8'($urandom_range(0, 254));
      send_word(w, $urandom_range(0, 2));
      repeat (2) @(negedge i_clk);
      model_build();
      checks++; if (got_addr.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", got_addr.size()); end
      else begin
         checks++; if (got_addr[0] !== exp_addr[0] || got_instr[0] !== exp_instr[0]) begin
            errors++; $display("FAIL rstmid_clean_word: got %h@%h expected %h@%h", got_instr[0], got_addr[0], exp_instr[0], exp_addr[0]);
         end
      end
      send_word(32'hFFFF_FFFF, 1);
      repeat (2) @(negedge i_clk);
   endtask

   task test_restart_from_done();
      checks++; if (bus.o_load_done !== 1'b1) begin errors++; $display("FAIL restart_pre_done: got %b expected 1", bus.o_load_done); end
      start_session();
      checks++; if (bus.o_load_done !== 1'b0) begin errors++; $display("FAIL restart_done_clear: got %b expected 0", bus.o_load_done); end
      send_word(32'h0000_0001, 1);
      repeat (2) @(negedge i_clk);
      checks++; if (got_addr.size() != 1) begin errors++; $display("FAIL restart_count: got %0d expected 1", got_addr.size()); end
      else begin
         checks++; if (got_addr[0] !== 32'h0 || got_instr[0] !== 32'h0000_0001) begin
            errors++; $display("FAIL restart_write: got %h@%h expected %h@%h", got_instr[0], got_addr[0], 32'h1, 32'h0);
         end
      end
      checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b expected 1", bus.o_busy); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_back_to_back();
      test_reset_mid();
      test_restart_from_done();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
